// File: rtl/bird_pkg.sv
// Shared definitions for the bird control FSM and its datapath:
// state codes, colours, screen geometry and the saturating step helper.
package bird_pkg;

  localparam logic [3:0] ST_HOLD    = 4'd0;
  localparam logic [3:0] ST_LEFT    = 4'd1;
  localparam logic [3:0] ST_RIGHT   = 4'd2;
  localparam logic [3:0] ST_UP      = 4'd3;
  localparam logic [3:0] ST_DOWN    = 4'd4;
  localparam logic [3:0] ST_CLEAR   = 4'd5;
  localparam logic [3:0] ST_DRAW    = 4'd6;
  localparam logic [3:0] ST_SHOT    = 4'd7;
  localparam logic [3:0] ST_ESCAPE  = 4'd8;
  localparam logic [3:0] ST_PREHOLD = 4'd9;

  localparam logic [2:0] BIRD_COL = 3'b110;
  localparam logic [2:0] SHOT_COL = 3'b100;
  localparam logic [2:0] BG_COL   = 3'b011;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_CLR,
    SW_DRW,
    SW_DONE
  } sweep_state_t;

  typedef enum logic [1:0] {
    ANIM_NONE,
    ANIM_SHOT,
    ANIM_ESCAPE
  } anim_mode_t;

  // Moves and falls saturate at the screen edge instead of wrapping.
  function automatic int sat_step(input int v, input int d, input int hi);
    int r;
    r = v + d;
    if (r < 0) r = 0;
    else if (r > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/sprite_sweep.sv
// Raster engine for one sprite: an optional background clear sweep,
// optionally chained straight into a paint sweep, then a one-cycle done.
module sprite_sweep
  import bird_pkg::*;
#(
  parameter int SPR_W = 4,
  parameter int SPR_H = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       do_clr,
  input  logic       do_drw,
  input  logic [7:0] clr_x,
  input  logic [6:0] clr_y,
  input  logic [7:0] drw_x,
  input  logic [6:0] drw_y,
  input  logic [2:0] drw_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       done,
  output logic       busy
);

  localparam int CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int CYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(SPR_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(SPR_H - 1);

  sweep_state_t   state;
  logic [CXW-1:0] cx, cx_nxt;
  logic [CYW-1:0] cy, cy_nxt;
  logic [7:0]     base_x, dx_q;
  logic [6:0]     base_y, dy_q;
  logic [2:0]     dcol_q;
  logic           drw_after;
  logic           last_px;

  assign last_px = (cx == CX_LAST) && (cy == CY_LAST);
  assign busy    = (state != SW_IDLE);

  always_comb begin
    cx_nxt = cx + 1'b1;
    cy_nxt = cy;
    if (cx == CX_LAST) begin
      cx_nxt = '0;
      cy_nxt = cy + 1'b1;
    end
  end

  // Outputs always show the pixel addressed by the current cx/cy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SW_IDLE;
      cx         <= '0;
      cy         <= '0;
      base_x     <= '0;
      base_y     <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      dcol_q     <= '0;
      drw_after  <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        SW_IDLE: begin
          done     <= 1'b0;
          vga_plot <= 1'b0;
          if (start && (do_clr || do_drw)) begin
            cx       <= '0;
            cy       <= '0;
            dx_q     <= drw_x;
            dy_q     <= drw_y;
            dcol_q   <= drw_colour;
            vga_plot <= 1'b1;
            if (do_clr) begin
              state      <= SW_CLR;
              drw_after  <= do_drw;
              base_x     <= clr_x;
              base_y     <= clr_y;
              vga_x      <= clr_x;
              vga_y      <= clr_y;
              vga_colour <= BG_COL;
            end else begin
              state      <= SW_DRW;
              drw_after  <= 1'b0;
              base_x     <= drw_x;
              base_y     <= drw_y;
              vga_x      <= drw_x;
              vga_y      <= drw_y;
              vga_colour <= drw_colour;
            end
          end
        end
        SW_CLR, SW_DRW: begin
          if (!last_px) begin
            cx    <= cx_nxt;
            cy    <= cy_nxt;
            vga_x <= base_x + 8'(cx_nxt);
            vga_y <= base_y + 7'(cy_nxt);
          end else if (drw_after) begin
            // Clear-then-paint runs back to back with no gap or done pulse.
            state      <= SW_DRW;
            drw_after  <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            base_x     <= dx_q;
            base_y     <= dy_q;
            vga_x      <= dx_q;
            vga_y      <= dy_q;
            vga_colour <= dcol_q;
          end else begin
            state    <= SW_DONE;
            vga_plot <= 1'b0;
            done     <= 1'b1;
          end
        end
        SW_DONE: begin
          state <= SW_IDLE;
          done  <= 1'b0;
        end
        default: state <= SW_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: position, entry detection, fall/escape animation and
// pending-request handling around the sprite sweep engine.
module bird_datapath
  import bird_pkg::*;
#(
  parameter int SPR_W     = 4,
  parameter int SPR_H     = 4,
  parameter int STEP      = 1,
  parameter int FALL_STEP = 2,
  parameter int SPAWN_X   = 76,
  parameter int SPAWN_Y   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state_in,
  input  logic       frame_tick,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       draw_done,
  output logic       flying,
  output logic [7:0] bird_x,
  output logic [6:0] bird_y
);

  localparam int X_LIM = SCR_W - SPR_W;
  localparam int Y_LIM = SCR_H - SPR_H;

  logic [3:0] prev_state, pend_code, req_code;
  logic       entry, entry_sweep;
  logic [7:0] drawn_x, upd_x;
  logic [6:0] drawn_y, upd_y, anim_y, drw_y;
  logic [2:0] drw_col;
  anim_mode_t anim_mode;
  logic       anim_spent, anim_last;
  logic       pending, upd_drawn, kill_on_done;
  logic       sweep_fire, anim_fire, start, do_clr, do_drw;
  logic       sw_busy, sw_done;
  int         ny;

  assign entry       = (state_in != prev_state);
  assign entry_sweep = entry && ((state_in == ST_CLEAR) || (state_in == ST_DRAW));
  assign draw_done   = sw_done;

  // Choose what, if anything, the sweep engine starts this cycle.
  always_comb begin
    ny        = int'(bird_y);
    anim_last = 1'b0;
    if (anim_mode == ANIM_SHOT) begin
      ny        = sat_step(int'(bird_y), FALL_STEP, Y_LIM);
      anim_last = (ny == Y_LIM);
    end else if (anim_mode == ANIM_ESCAPE) begin
      ny        = sat_step(int'(bird_y), -FALL_STEP, Y_LIM);
      anim_last = (ny == 0);
    end
    anim_y = 7'(ny);

    req_code = ST_HOLD;
    if (entry_sweep) req_code = state_in;
    else if (pending) req_code = pend_code;

    sweep_fire = !sw_busy && ((req_code == ST_CLEAR) || (req_code == ST_DRAW));
    anim_fire  = !sw_busy && !sweep_fire && frame_tick &&
                 (anim_mode != ANIM_NONE) && !anim_spent;
    start      = sweep_fire || anim_fire;
    do_clr     = anim_fire || (sweep_fire && (req_code == ST_CLEAR));
    do_drw     = (anim_fire && !anim_last) || (sweep_fire && (req_code == ST_DRAW));
    drw_y      = anim_fire ? anim_y : bird_y;
    drw_col    = (anim_fire && (anim_mode == ANIM_SHOT)) ? SHOT_COL : BIRD_COL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state   <= ST_HOLD;
      bird_x       <= 8'(SPAWN_X);
      bird_y       <= 7'(SPAWN_Y);
      drawn_x      <= 8'(SPAWN_X);
      drawn_y      <= 7'(SPAWN_Y);
      flying       <= 1'b1;
      anim_mode    <= ANIM_NONE;
      anim_spent   <= 1'b0;
      pending      <= 1'b0;
      pend_code    <= ST_HOLD;
      upd_drawn    <= 1'b0;
      kill_on_done <= 1'b0;
      upd_x        <= '0;
      upd_y        <= '0;
    end else begin
      prev_state <= state_in;

      // The drawn position only moves once its paint sweep has finished.
      if (sw_done) begin
        if (upd_drawn) begin
          drawn_x <= upd_x;
          drawn_y <= upd_y;
        end
        if (kill_on_done) flying <= 1'b0;
        upd_drawn    <= 1'b0;
        kill_on_done <= 1'b0;
      end

      if (entry_sweep && sw_busy) begin
        pending   <= 1'b1;
        pend_code <= state_in;
      end else if (sweep_fire) begin
        pending <= 1'b0;
      end

      if (sweep_fire && (req_code == ST_DRAW)) begin
        upd_drawn <= 1'b1;
        upd_x     <= bird_x;
        upd_y     <= bird_y;
      end

      if (anim_fire) begin
        anim_spent <= anim_last;
        bird_y     <= anim_y;
        if (anim_last) begin
          kill_on_done <= 1'b1;
        end else begin
          upd_drawn <= 1'b1;
          upd_x     <= bird_x;
          upd_y     <= anim_y;
        end
      end

      if (entry) begin
        case (state_in)
          ST_LEFT:   bird_x <= 8'(sat_step(int'(bird_x), -STEP, X_LIM));
          ST_RIGHT:  bird_x <= 8'(sat_step(int'(bird_x), STEP, X_LIM));
          ST_UP:     bird_y <= 7'(sat_step(int'(bird_y), -STEP, Y_LIM));
          ST_DOWN:   bird_y <= 7'(sat_step(int'(bird_y), STEP, Y_LIM));
          ST_SHOT: begin
            anim_mode  <= ANIM_SHOT;
            anim_spent <= 1'b0;
          end
          ST_ESCAPE: begin
            anim_mode  <= ANIM_ESCAPE;
            anim_spent <= 1'b0;
          end
          ST_PREHOLD: begin
            bird_x       <= 8'(SPAWN_X);
            bird_y       <= 7'(SPAWN_Y);
            drawn_x      <= 8'(SPAWN_X);
            drawn_y      <= 7'(SPAWN_Y);
            anim_mode    <= ANIM_NONE;
            anim_spent   <= 1'b0;
            flying       <= 1'b1;
            upd_drawn    <= 1'b0;
            kill_on_done <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  sprite_sweep #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H)
  ) u_sweep (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .do_clr    (do_clr),
    .do_drw    (do_drw),
    .clr_x     (drawn_x),
    .clr_y     (drawn_y),
    .drw_x     (bird_x),
    .drw_y     (drw_y),
    .drw_colour(drw_col),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .done      (sw_done),
    .busy      (sw_busy)
  );

endmodule

// File: tb/tb_bird_datapath.sv
// Self-checking bench for bird_datapath: vector table, directed corner
// sequences and a randomized walk against a plain positional model.
module tb_bird_datapath;

  localparam logic [3:0] S_HOLD = 4'd0, S_LEFT = 4'd1, S_RIGHT = 4'd2, S_UP = 4'd3;
  localparam logic [3:0] S_DOWN = 4'd4, S_CLEAR = 4'd5, S_DRAW = 4'd6, S_SHOT = 4'd7;
  localparam logic [3:0] S_ESCAPE = 4'd8, S_PREHOLD = 4'd9;
  localparam int C_BIRD = 6, C_SHOT = 4, C_BG = 3;
  localparam int SW = 4, SH = 4, XMAX = 156, YMAX = 116;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state_in;
  logic       frame_tick;
  logic [7:0] vga_x, bird_x;
  logic [6:0] vga_y, bird_y;
  logic [2:0] vga_colour;
  logic       vga_plot, draw_done, flying;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] st;
    logic       ft;
    int         exp_x;
    int         exp_y;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  bird_datapath dut (
    .clk       (clk),
    .reset     (reset),
    .state_in  (state_in),
    .frame_tick(frame_tick),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .draw_done (draw_done),
    .flying    (flying),
    .bird_x    (bird_x),
    .bird_y    (bird_y)
  );

  function automatic int pix(input int p, input int x, input int y, input int c);
    return (p << 24) | (x << 12) | (y << 4) | c;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] st, input logic ft);
    state_in   = st;
    frame_tick = ft;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic doReset();
    reset      = 1'b1;
    state_in   = S_HOLD;
    frame_tick = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic moveN(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(st, 1'b0);
      applyStimulus(S_HOLD, 1'b0);
    end
  endtask

  task automatic watchQuiet(input string name, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (vga_plot || draw_done) n++;
      tick();
    end
    checkOutput(name, n, 0);
  endtask

  // Expects one SWxSH raster at (x0,y0); optional state changes mid-sweep.
  task automatic expectSweep(input string name, input int x0, input int y0, input int col,
                             input int max_wait, input bit expect_done,
                             input int inj_a_at = -1, input logic [3:0] inj_a = 4'd0,
                             input int inj_b_at = -1, input logic [3:0] inj_b = 4'd0);
    int w = 0;
    while (vga_plot !== 1'b1 && w < max_wait) begin
      tick();
      w++;
    end
    if (vga_plot !== 1'b1) begin
      checkOutput({name, " start"}, 0, 1);
      return;
    end
    for (int i = 0; i < SW * SH; i++) begin
      if (i == inj_a_at) state_in = inj_a;
      if (i == inj_b_at) state_in = inj_b;
      checkOutput($sformatf("%s px%0d", name, i),
                  pix(vga_plot, vga_x, vga_y, vga_colour),
                  pix(1, x0 + i % SW, y0 + i / SW, col));
      tick();
    end
    if (expect_done) begin
      checkOutput({name, " done"}, int'({vga_plot, draw_done}), 1);
      tick();
      checkOutput({name, " done width"}, int'(draw_done), 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int mx, my, mdx, mdy, y, nyv, r;
    logic [3:0] code;

    vecs[0]  = '{S_HOLD,   1'b0, 76, 100};
    vecs[1]  = '{S_RIGHT,  1'b0, 77, 100};
    vecs[2]  = '{S_RIGHT,  1'b1, 77, 100};
    vecs[3]  = '{S_HOLD,   1'b0, 77, 100};
    vecs[4]  = '{S_UP,     1'b0, 77, 99};
    vecs[5]  = '{S_LEFT,   1'b1, 76, 99};
    vecs[6]  = '{S_DOWN,   1'b0, 76, 100};
    vecs[7]  = '{S_DOWN,   1'b0, 76, 100};
    vecs[8]  = '{S_HOLD,   1'b0, 76, 100};
    vecs[9]  = '{S_DOWN,   1'b0, 76, 101};
    vecs[10] = '{S_LEFT,   1'b0, 75, 101};

    doReset();
    checkOutput("reset bird_x", int'(bird_x), 76);
    checkOutput("reset bird_y", int'(bird_y), 100);
    checkOutput("reset flying", int'(flying), 1);
    checkOutput("reset vga", pix(vga_plot, vga_x, vga_y, vga_colour), 0);
    checkOutput("reset draw_done", int'(draw_done), 0);

    // Clear at spawn with exact first-pixel latency and done timing.
    applyStimulus(S_CLEAR, 1'b0);
    checkOutput("t1 first pixel latency", int'(vga_plot), 1);
    expectSweep("t1 clear", 76, 100, C_BG, 0, 1'b1);

    applyStimulus(S_RIGHT, 1'b0);
    checkOutput("t2 bird_x", int'(bird_x), 77);
    applyStimulus(S_CLEAR, 1'b0);
    expectSweep("t2 clear", 76, 100, C_BG, 0, 1'b1);
    applyStimulus(S_DRAW, 1'b0);
    expectSweep("t2 draw", 77, 100, C_BIRD, 0, 1'b1);

    doReset();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].st, vecs[i].ft);
      checkOutput($sformatf("vec%0d x", i), int'(bird_x), vecs[i].exp_x);
      checkOutput($sformatf("vec%0d y", i), int'(bird_y), vecs[i].exp_y);
      checkOutput($sformatf("vec%0d plot", i), int'(vga_plot), 0);
    end

    doReset();
    moveN(S_RIGHT, 80);
    checkOutput("t3 right to edge", int'(bird_x), XMAX);
    moveN(S_RIGHT, 1);
    checkOutput("t3 right clamp", int'(bird_x), XMAX);
    moveN(S_LEFT, 156);
    checkOutput("t3 left to edge", int'(bird_x), 0);
    moveN(S_LEFT, 1);
    checkOutput("t3 left clamp", int'(bird_x), 0);
    moveN(S_UP, 100);
    checkOutput("t3 up to edge", int'(bird_y), 0);
    moveN(S_UP, 1);
    checkOutput("t3 up clamp", int'(bird_y), 0);
    moveN(S_DOWN, 117);
    checkOutput("t3 down clamp", int'(bird_y), YMAX);

    // Random walk: clamped moves, draws at logical, clears at last drawn.
    doReset();
    mx = 76; my = 100; mdx = 76; mdy = 100;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 5);
      code = (r == 0) ? S_LEFT : (r == 1) ? S_RIGHT : (r == 2) ? S_UP :
             (r == 3) ? S_DOWN : (r == 4) ? S_DRAW : S_CLEAR;
      applyStimulus(S_HOLD, 1'($urandom_range(0, 1)));
      applyStimulus(code, 1'($urandom_range(0, 1)));
      case (r)
        0: mx = (mx > 0) ? mx - 1 : 0;
        1: mx = (mx < XMAX) ? mx + 1 : XMAX;
        2: my = (my > 0) ? my - 1 : 0;
        3: my = (my < YMAX) ? my + 1 : YMAX;
        default: ;
      endcase
      if (r == 4) begin
        expectSweep($sformatf("rnd%0d draw", i), mx, my, C_BIRD, 0, 1'b1);
        mdx = mx; mdy = my;
      end else if (r == 5) begin
        expectSweep($sformatf("rnd%0d clear", i), mdx, mdy, C_BG, 0, 1'b1);
      end else begin
        checkOutput($sformatf("rnd%0d pos", i), (int'(bird_x) << 8) | int'(bird_y), (mx << 8) | my);
      end
    end

    // Shot: fall two pixels per frame until the floor, then clear-only.
    doReset();
    applyStimulus(S_SHOT, 1'b0);
    y = 100;
    for (int k = 0; k < 20; k++) begin
      nyv = (y + 2 > YMAX) ? YMAX : y + 2;
      applyStimulus(S_SHOT, 1'b1);
      expectSweep($sformatf("t4 clr y%0d", y), 76, y, C_BG, 0, nyv == YMAX);
      if (nyv != YMAX) expectSweep($sformatf("t4 drw y%0d", nyv), 76, nyv, C_SHOT, 0, 1'b1);
      y = nyv;
      if (nyv == YMAX) break;
    end
    checkOutput("t4 flying cleared", int'(flying), 0);
    checkOutput("t4 bird_y floor", int'(bird_y), YMAX);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(S_SHOT, 1'b1);
      watchQuiet($sformatf("t4 ignored tick%0d", k), 5);
    end

    applyStimulus(S_PREHOLD, 1'b0);
    moveN(S_UP, 96);
    checkOutput("t5 y before escape", int'(bird_y), 4);
    applyStimulus(S_DRAW, 1'b0);
    expectSweep("t5 draw", 76, 4, C_BIRD, 0, 1'b1);
    applyStimulus(S_ESCAPE, 1'b0);
    applyStimulus(S_ESCAPE, 1'b1);
    expectSweep("t5 clr y4", 76, 4, C_BG, 0, 1'b0);
    expectSweep("t5 drw y2", 76, 2, C_BIRD, 0, 1'b1);
    applyStimulus(S_ESCAPE, 1'b1);
    expectSweep("t5 clr y2", 76, 2, C_BG, 0, 1'b1);
    checkOutput("t5 flying cleared", int'(flying), 0);
    checkOutput("t5 bird_y top", int'(bird_y), 0);
    applyStimulus(S_PREHOLD, 1'b0);
    checkOutput("t5 prehold flying", int'(flying), 1);
    checkOutput("t5 prehold pos", (int'(bird_x) << 8) | int'(bird_y), (76 << 8) | 100);
    watchQuiet("t5 prehold quiet", 6);

    // DRAW arriving mid-clear is queued and starts after DONE.
    doReset();
    applyStimulus(S_CLEAR, 1'b0);
    expectSweep("t6 clear", 76, 100, C_BG, 0, 1'b1, 5, S_DRAW);
    checkOutput("t6 gap after done", int'(vga_plot), 0);
    tick();
    expectSweep("t6 pending draw", 76, 100, C_BIRD, 0, 1'b1);

    applyStimulus(S_HOLD, 1'b0);
    applyStimulus(S_RIGHT, 1'b0);
    applyStimulus(S_HOLD, 1'b0);
    applyStimulus(S_CLEAR, 1'b0);
    expectSweep("t6b clear", 76, 100, C_BG, 0, 1'b1, 3, S_DRAW, 8, S_CLEAR);
    checkOutput("t6b gap after done", int'(vga_plot), 0);
    tick();
    expectSweep("t6b latest wins", 76, 100, C_BG, 0, 1'b1);
    watchQuiet("t6b no extra sweep", 20);

    applyStimulus(S_HOLD, 1'b0);
    applyStimulus(S_DRAW, 1'b0);
    checkOutput("t6c sweep running", int'(vga_plot), 1);
    for (int i = 0; i < 4; i++) tick();
    reset    = 1'b1;
    state_in = S_HOLD;
    tick();
    checkOutput("t6c reset vga", pix(vga_plot, vga_x, vga_y, vga_colour), 0);
    checkOutput("t6c reset pos", (int'(bird_x) << 8) | int'(bird_y), (76 << 8) | 100);
    checkOutput("t6c reset flags", int'({flying, draw_done}), 2);
    reset = 1'b0;
    watchQuiet("t6c sweep abandoned", 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
